// File: rtl/bus_initiator.sv
// Initiator side of the pipelined req/addressAck/readAck/writeAck bus: a command FIFO,
// a request FSM, outstanding-transaction counters, request timeout and responder error flags.
module bus_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CMD_DEPTH       = 4,
  parameter int REQ_TIMEOUT     = 64
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_cmdValid,
  input  logic       i_cmdReadWrite_n,
  output logic       o_cmdReady,
  output logic       o_req,
  output logic       o_readWrite_n,
  input  logic       i_addressAck,
  input  logic       i_readAck,
  input  logic       i_writeAck,
  output logic [2:0] o_pendingReads,
  output logic [2:0] o_pendingWrites,
  output logic       o_readDone,
  output logic       o_writeDone,
  output logic       o_idle,
  output logic       o_timeout,
  output logic       o_protocolError,
  output logic [1:0] o_dbgState
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam logic [3:0]    MAX_OUT  = 4'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] FIFO_MAX = CW'(CMD_DEPTH);
  localparam logic [TW-1:0] TO_LIMIT = TW'(REQ_TIMEOUT);

  // Handshake: a command is taken on any rising edge where i_cmdValid && o_cmdReady;
  // a bus request is accepted on any rising edge where o_req && i_addressAck.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CMD_DEPTH-1:0] fifo_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [3:0]           total_q, total_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 timeout_q, timeout_d;
  logic                 perr_q, perr_d;
  logic                 rd_done_q, wr_done_q;

  logic full, push, accept, head;
  logic rd_acc, wr_acc, rd_ack_ok, wr_ack_ok;

  assign full   = (cnt_q == FIFO_MAX);
  assign push   = i_cmdValid && !full;
  assign head   = fifo_q[rd_ptr_q];
  assign accept = o_req && i_addressAck;
  assign rd_acc = accept && head;
  assign wr_acc = accept && !head;

  // A write may be acked in the same cycle it is accepted; reads never complete that early.
  assign rd_ack_ok = i_readAck && (rd_pend_q != 3'd0);
  assign wr_ack_ok = i_writeAck && ((wr_pend_q != 3'd0) || wr_acc);

  assign cnt_d     = cnt_q + CW'(push) - CW'(accept);
  assign rd_pend_d = rd_pend_q + 3'(rd_acc) - 3'(rd_ack_ok);
  assign wr_pend_d = wr_pend_q + 3'(wr_acc) - 3'(wr_ack_ok);
  assign total_q   = {1'b0, rd_pend_q} + {1'b0, wr_pend_q};
  assign total_d   = {1'b0, rd_pend_d} + {1'b0, wr_pend_d};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((cnt_q != '0) && (total_q < MAX_OUT)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (accept) begin
          if (total_d == MAX_OUT)   state_d = ST_STALL;
          else if (cnt_d != '0)     state_d = ST_REQ;
          else                      state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (total_q < MAX_OUT) state_d = (cnt_q != '0) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The wait counter saturates at the limit so the sticky flag cannot be missed.
  always_comb begin
    tcnt_d = tcnt_q;
    if (!o_req || i_addressAck)  tcnt_d = '0;
    else if (tcnt_q != TO_LIMIT) tcnt_d = tcnt_q + TW'(1);
    timeout_d = timeout_q || (tcnt_d == TO_LIMIT);
    perr_d = perr_q
          || (i_readAck && (rd_pend_q == 3'd0))
          || (i_writeAck && (wr_pend_q == 3'd0) && !wr_acc)
          || (i_addressAck && !o_req);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= ST_IDLE;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 3'd0;
      wr_pend_q <= 3'd0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= i_cmdReadWrite_n;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (accept) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
      perr_q    <= perr_d;
      rd_done_q <= rd_ack_ok;
      wr_done_q <= wr_ack_ok;
    end
  end

  assign o_cmdReady      = !full;
  assign o_req           = (state_q == ST_REQ);
  assign o_readWrite_n   = o_req && head;
  assign o_pendingReads  = rd_pend_q;
  assign o_pendingWrites = wr_pend_q;
  assign o_readDone      = rd_done_q;
  assign o_writeDone     = wr_done_q;
  assign o_idle          = (cnt_q == '0) && !o_req && (total_q == 4'd0);
  assign o_timeout       = timeout_q;
  assign o_protocolError = perr_q;
  assign o_dbgState      = state_q;

endmodule
